// File: rtl/hc323_pkg.sv
// Shared definitions for the hc323 shift/storage register: mode encoding and bus width.
package hc_pkg;

   localparam int BUS_W = 8;

   typedef enum logic [1:0] {
      HOLD = 2'b00,
      SHR  = 2'b01,
      SHL  = 2'b10,
      LOAD = 2'b11
   } mode_t;

endpackage

// File: rtl/hc323.sv
// 74HC323 8-bit universal shift/storage register, pin-numbered ports, shared 3-state I/O bus.
// Optional simulation checker enabled by defining HC323_BUS_CONTENTION_CHECK_EN.
module hc323
   import hc_pkg::*;
(
   input  logic p12,   // CP
   input  logic p9,    // MR_n
   input  logic p1,    // S0
   input  logic p19,   // S1
   input  logic p2,    // OE1_n
   input  logic p3,    // OE2_n
   input  logic p11,   // DSR
   input  logic p18,   // DSL
   inout  wire  p7,    // I/O0
   inout  wire  p13,   // I/O1
   inout  wire  p6,    // I/O2
   inout  wire  p14,   // I/O3
   inout  wire  p5,    // I/O4
   inout  wire  p15,   // I/O5
   inout  wire  p4,    // I/O6
   inout  wire  p16,   // I/O7
   output logic p8,    // Q0
   output logic p17    // Q7
);

   logic [BUS_W-1:0] r_q;
   logic [BUS_W-1:0] w_q_nxt;
   logic [BUS_W-1:0] w_bus_in;
   logic [BUS_W-1:0] w_bus_out;
   logic             w_drive;
   mode_t            w_mode;

   assign w_mode = mode_t'({p19, p1});

   // Pin-to-bit map of the shared bus: I/O7..I/O0.
   assign {p16, p4, p15, p5, p14, p6, p13, p7} = w_bus_out;
   assign w_bus_in = {p16, p4, p15, p5, p14, p6, p13, p7};

   // Load mode always releases the bus so a load never samples its own drive.
   assign w_drive   = !p2 && !p3 && (w_mode != LOAD);
   assign w_bus_out = w_drive ? r_q : {BUS_W{1'bz}};

   always_comb begin
      w_q_nxt = r_q;
      case (w_mode)
         HOLD: w_q_nxt = r_q;
         SHR:  w_q_nxt = {r_q[BUS_W-2:0], p11};
         SHL:  w_q_nxt = {p18, r_q[BUS_W-1:1]};
         LOAD: w_q_nxt = w_bus_in;
         default: w_q_nxt = r_q;
      endcase
   end

   always_ff @(posedge p12) begin
      if (!p9) r_q <= '0;
      else     r_q <= w_q_nxt;
   end

   assign p8  = r_q[0];
   assign p17 = r_q[BUS_W-1];

`ifdef HC323_BUS_CONTENTION_CHECK_EN
   always @(posedge p12) begin
      if ($isunknown({p19, p1, p11, p18, p9}))
         $error("hc323: unknown control/serial input at clock edge, time %0t", $time);
   end

   // An X while driving means another driver is fighting the part on that pin.
   always @* begin
      if (w_drive) begin
         for (int i = 0; i < BUS_W; i++) begin
            if ($isunknown(w_bus_in[i]))
               $error("hc323: bus contention at time %0t on bit %0d", $time, i);
         end
      end
   end
`endif

endmodule

// File: tb/tb_hc323.sv
// Directed self-checking bench for hc323; bus pins carry pull-ups so a released bus reads 8'hFF.
module tb_hc323;

   logic clk = 1'b0;
   logic mr_n, s0, s1, oe1_n, oe2_n, dsr, dsl;
   logic [7:0] drv_val;
   logic       drv_en;
   wire  p7, p13, p6, p14, p5, p15, p4, p16;
   logic q0, q7;
   wire  [7:0] bus = {p16, p4, p15, p5, p14, p6, p13, p7};

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   assign {p16, p4, p15, p5, p14, p6, p13, p7} = drv_en ? drv_val : 8'hzz;
   pullup (p7);  pullup (p13); pullup (p6);  pullup (p14);
   pullup (p5);  pullup (p15); pullup (p4);  pullup (p16);

   hc323 dut (
      .p12(clk), .p9(mr_n), .p1(s0), .p19(s1), .p2(oe1_n), .p3(oe2_n),
      .p11(dsr), .p18(dsl),
      .p7(p7), .p13(p13), .p6(p6), .p14(p14), .p5(p5), .p15(p15), .p4(p4), .p16(p16),
      .p8(q0), .p17(q7)
   );

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [7:0] v);
      drv_val = v; drv_en = 1'b1; {s1, s0} = 2'b11;
      tick();
      drv_en = 1'b0; {s1, s0} = 2'b00;
      #1;
   endtask

   initial begin
      mr_n = 1'b0; s0 = 1'b0; s1 = 1'b0; oe1_n = 1'b0; oe2_n = 1'b0;
      dsr = 1'b0; dsl = 1'b0; drv_val = 8'h00; drv_en = 1'b0;

      // Reset with outputs enabled, hold mode
      tick();
      chk("rst_bus", bus, 8'h00);
      chk("rst_q0", {7'd0, q0}, 8'h00);
      chk("rst_q7", {7'd0, q7}, 8'h00);

      // Reset wins over load mode; bus released while S=11
      load(8'hA5);
      {s1, s0} = 2'b11; mr_n = 1'b0;
      tick();
      chk("rst_load_bus_z", bus, 8'hFF);
      chk("rst_load_q0", {7'd0, q0}, 8'h00);
      {s1, s0} = 2'b00; #1;
      chk("rst_load_q", bus, 8'h00);
      mr_n = 1'b1;

      // Load and readback
      load(8'hA5);
      chk("load_a5_bus", bus, 8'hA5);
      chk("load_a5_q0q7", {6'd0, q7, q0}, 8'h03);

      // Hold keeps value across an edge
      tick();
      chk("hold_bus", bus, 8'hA5);

      // Shift right: 81 -> 02, then DSR=1
      load(8'h81);
      {s1, s0} = 2'b01; dsr = 1'b0;
      tick();
      chk("shr_02", bus, 8'h02);
      chk("shr_02_q0q7", {6'd0, q7, q0}, 8'h00);
      dsr = 1'b1;
      tick();
      chk("shr_05", bus, 8'h05);
      for (int i = 0; i < 7; i++) tick();
      chk("shr_ff_q0q7", {6'd0, q7, q0}, 8'h03);
      {s1, s0} = 2'b00; #1;
      chk("shr_ff", bus, 8'hFF);

      // Eight right shifts of zero flush everything, no wrap
      {s1, s0} = 2'b01; dsr = 1'b0;
      for (int i = 0; i < 8; i++) tick();
      chk("shr_flush", bus, 8'h00);

      // Shift left: 81 -> C0
      load(8'h81);
      {s1, s0} = 2'b10; dsl = 1'b1;
      tick();
      chk("shl_c0", bus, 8'hC0);
      chk("shl_c0_q0q7", {6'd0, q7, q0}, 8'h02);

      // Shift left drops bit 0
      load(8'h01);
      {s1, s0} = 2'b10; dsl = 1'b0;
      tick();
      chk("shl_drop", bus, 8'h00);

      // Output enables
      load(8'h3C);
      oe1_n = 1'b1; #1;
      chk("oe1_off_bus", bus, 8'hFF);
      chk("oe1_off_q0q7", {6'd0, q7, q0}, 8'h00);
      oe1_n = 1'b0; oe2_n = 1'b1; #1;
      chk("oe2_off_bus", bus, 8'hFF);
      oe2_n = 1'b0; #1;
      chk("oe_on_bus", bus, 8'h3C);
      {s1, s0} = 2'b11; #1;
      chk("load_mode_release", bus, 8'hFF);
      {s1, s0} = 2'b00; #1;
      chk("after_release", bus, 8'h3C);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
